// File: rtl/operand_fetch_sequencer.sv
// operand_fetch_sequencer: issues register reads, collects operands and hands them to execute.
// Define OFS_WB_BYPASS_EN to let writebacks refresh operands held in WAIT/VALID.
module operand_fetch_sequencer (
  input  logic       clock,
  input  logic       resetN,
  input  logic       issueValid,
  output logic       issueReady,
  input  logic [2:0] issueRs1,
  input  logic [2:0] issueRs2,
  input  logic       issueImm,
  input  logic [7:0] issueLt,
  input  logic       wbValid,
  input  logic [2:0] wbReg,
  input  logic [7:0] wbData,
  output logic [2:0] rfReadRegister1,
  output logic [2:0] rfReadRegister2,
  output logic       rfImmediate,
  output logic [7:0] rfLtValue,
  output logic       rfRegWrite,
  output logic [7:0] rfWriteData,
  input  logic [7:0] rfReadData1,
  input  logic [7:0] rfReadData2,
  output logic       opValid,
  input  logic       opReady,
  output logic [7:0] opA,
  output logic [7:0] opB
);
  typedef enum logic [1:0] {IDLE, READ, WAIT, VALID} state_t;
  state_t     state, state_nxt;
  logic [2:0] rs1_q, rs2_q;
  logic       imm_q;
  logic [7:0] lt_q, op_a_nxt, op_b_nxt;
  logic       accept;
  assign issueReady      = (state == IDLE) || (state == VALID && opReady);
  assign accept          = issueValid && issueReady;
  assign opValid         = state == VALID;
  assign rfRegWrite      = wbValid;
  assign rfWriteData     = wbData;
  // The write port shares address 1, so a writeback steals it from the read.
  assign rfReadRegister1 = wbValid ? wbReg : rs1_q;
  assign rfReadRegister2 = rs2_q;
  assign rfImmediate     = imm_q;
  assign rfLtValue       = lt_q;
  always_comb begin
    state_nxt = state;
    op_a_nxt  = opA;
    op_b_nxt  = opB;
    case (state)
      IDLE:    state_nxt = accept ? READ : IDLE;
      READ:    state_nxt = wbValid ? READ : WAIT;
      WAIT: begin
        state_nxt = VALID;
        op_a_nxt  = rfReadData1;
        op_b_nxt  = imm_q ? lt_q : rfReadData2;
      end
      VALID:   state_nxt = opReady ? (accept ? READ : IDLE) : VALID;
      default: state_nxt = IDLE;
    endcase
`ifdef OFS_WB_BYPASS_EN
    if (wbValid && (state == WAIT || state == VALID)) begin
      if (wbReg == rs1_q) op_a_nxt = wbData;
      if (!imm_q && wbReg == rs2_q) op_b_nxt = wbData;
    end
`endif
  end
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state <= IDLE;
      opA   <= '0;
      opB   <= '0;
      rs1_q <= '0;
      rs2_q <= '0;
      imm_q <= 1'b0;
      lt_q  <= '0;
    end else begin
      state <= state_nxt;
      opA   <= op_a_nxt;
      opB   <= op_b_nxt;
      if (accept) begin
        rs1_q <= issueRs1;
        rs2_q <= issueRs2;
        imm_q <= issueImm;
        lt_q  <= issueLt;
      end
    end
  end
endmodule
